// File: rtl/in_splitter.sv
`default_nettype none
// ============================================================================
// in_splitter : routes a single-byte-key tagged byte stream into a varint FIFO
//               and a length-delimited (raw) FIFO, tagging each byte with its
//               field index.
// Revision    : 1.0
// ============================================================================
module in_splitter (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_fifo_empty,
  input  logic [7:0] in_fifo_q,
  output logic       in_fifo_pop,
  input  logic       varint_fifo_full,
  output logic       varint_fifo_clr,
  output logic       varint_fifo_push,
  output logic [7:0] varint_fifo_data,
  output logic [9:0] varint_index,
  input  logic       raw_data_fifo_full,
  output logic       raw_data_fifo_clr,
  output logic       raw_data_fifo_push,
  output logic [7:0] raw_data_fifo_data,
  output logic [9:0] raw_data_index,
  output logic       parse_error
);

  typedef enum logic [5:0] {
    ST_INIT   = 6'b000001,
    ST_KEY    = 6'b000010,
    ST_LEN    = 6'b000100,
    ST_V_DATA = 6'b001000,
    ST_R_DATA = 6'b010000,
    ST_ERROR  = 6'b100000
  } state_t;

  localparam logic [2:0] WT_VARINT        = 3'd0;
  localparam logic [2:0] WT_LEN_DELIM     = 3'd2;
  localparam logic [3:0] VARINT_MAX_BYTES = 4'd10;

  state_t     state_q, state_d;
  logic [9:0] field_index_q, field_index_d;
  logic [6:0] remain_q, remain_d;
  logic [3:0] vcount_q, vcount_d;

  logic pop, vpush, rpush, clr;

  always_comb begin
    state_d       = state_q;
    field_index_d = field_index_q;
    remain_d      = remain_q;
    vcount_d      = vcount_q;
    pop           = 1'b0;
    vpush         = 1'b0;
    rpush         = 1'b0;
    clr           = 1'b0;

    case (state_q)
      ST_INIT: begin
        clr           = 1'b1;
        field_index_d = '0;
        remain_d      = '0;
        vcount_d      = '0;
        state_d       = ST_KEY;
      end

      ST_KEY: begin
        if (!in_fifo_empty) begin
          pop = 1'b1;
          if (in_fifo_q[7]) begin
            state_d = ST_ERROR;
          end else if (in_fifo_q[2:0] == WT_VARINT) begin
            vcount_d = '0;
            state_d  = ST_V_DATA;
          end else if (in_fifo_q[2:0] == WT_LEN_DELIM) begin
            state_d = ST_LEN;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end

      ST_LEN: begin
        if (!in_fifo_empty) begin
          pop = 1'b1;
          if (in_fifo_q[7]) begin
            state_d = ST_ERROR;
          end else if (in_fifo_q == 8'h00) begin
            // Empty field: nothing is emitted, so its index is not consumed.
            state_d = ST_KEY;
          end else begin
            remain_d = in_fifo_q[6:0];
            state_d  = ST_R_DATA;
          end
        end
      end

      ST_R_DATA: begin
        if (!in_fifo_empty && !raw_data_fifo_full) begin
          pop      = 1'b1;
          rpush    = 1'b1;
          remain_d = remain_q - 7'd1;
          if (remain_q == 7'd1) begin
            field_index_d = field_index_q + 10'd1;
            state_d       = ST_KEY;
          end
        end
      end

      ST_V_DATA: begin
        if (!in_fifo_empty && !varint_fifo_full) begin
          pop      = 1'b1;
          vpush    = 1'b1;
          vcount_d = vcount_q + 4'd1;
          if (!in_fifo_q[7]) begin
            field_index_d = field_index_q + 10'd1;
            state_d       = ST_KEY;
          end else if (vcount_q == VARINT_MAX_BYTES - 4'd1) begin
            state_d = ST_ERROR;
          end
        end
      end

      ST_ERROR: begin
        state_d = ST_ERROR;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_INIT;
      field_index_q <= '0;
      remain_q      <= '0;
      vcount_q      <= '0;
    end else begin
      state_q       <= state_d;
      field_index_q <= field_index_d;
      remain_q      <= remain_d;
      vcount_q      <= vcount_d;
    end
  end

  // Reset forces every output low immediately, even before the state register
  // has been reloaded, so a mid-field reset cannot pop or push.
  assign in_fifo_pop        = reset & pop;
  assign varint_fifo_push   = reset & vpush;
  assign raw_data_fifo_push = reset & rpush;
  assign varint_fifo_clr    = reset & clr;
  assign raw_data_fifo_clr  = reset & clr;
  assign varint_fifo_data   = varint_fifo_push   ? in_fifo_q : 8'h00;
  assign raw_data_fifo_data = raw_data_fifo_push ? in_fifo_q : 8'h00;
  assign varint_index       = reset ? field_index_q : 10'd0;
  assign raw_data_index     = reset ? field_index_q : 10'd0;
  assign parse_error        = reset & (state_q == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_in_splitter.sv
`default_nettype none
// ============================================================================
// tb_in_splitter : table vectors, corner sequences and randomized streams
//                  checked against a stream-level parsing model.
// Revision       : 1.0
// ============================================================================
module tb_in_splitter;

  logic       clk;
  logic       reset;
  logic       in_fifo_empty;
  logic [7:0] in_fifo_q;
  logic       in_fifo_pop;
  logic       varint_fifo_full;
  logic       varint_fifo_clr;
  logic       varint_fifo_push;
  logic [7:0] varint_fifo_data;
  logic [9:0] varint_index;
  logic       raw_data_fifo_full;
  logic       raw_data_fifo_clr;
  logic       raw_data_fifo_push;
  logic [7:0] raw_data_fifo_data;
  logic [9:0] raw_data_index;
  logic       parse_error;

  in_splitter dut (
    .clk                (clk),
    .reset              (reset),
    .in_fifo_empty      (in_fifo_empty),
    .in_fifo_q          (in_fifo_q),
    .in_fifo_pop        (in_fifo_pop),
    .varint_fifo_full   (varint_fifo_full),
    .varint_fifo_clr    (varint_fifo_clr),
    .varint_fifo_push   (varint_fifo_push),
    .varint_fifo_data   (varint_fifo_data),
    .varint_index       (varint_index),
    .raw_data_fifo_full (raw_data_fifo_full),
    .raw_data_fifo_clr  (raw_data_fifo_clr),
    .raw_data_fifo_push (raw_data_fifo_push),
    .raw_data_fifo_data (raw_data_fifo_data),
    .raw_data_index     (raw_data_index),
    .parse_error        (parse_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  src[$];
  logic [7:0]  stream[$];
  logic [17:0] got_v[$];
  logic [17:0] got_r[$];
  logic [17:0] exp_v[$];
  logic [17:0] exp_r[$];
  int          pops;
  int          exp_pops;
  logic        exp_err;
  logic        rst_drv;
  logic        v_full, r_full, hold_src, rand_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive after the falling edge, sample 1ns later, commit pops.
  task automatic step();
    @(negedge clk);
    if (rand_mode) begin
      v_full   = ($urandom_range(0, 3) == 0);
      r_full   = ($urandom_range(0, 3) == 0);
      hold_src = ($urandom_range(0, 3) == 0);
    end
    reset              = rst_drv;
    in_fifo_empty      = (src.size() == 0) || hold_src;
    in_fifo_q          = (src.size() != 0) ? src[0] : 8'h00;
    varint_fifo_full   = v_full;
    raw_data_fifo_full = r_full;
    #1;
    if (varint_fifo_push || raw_data_fifo_push) begin
      chk("dual_push", 64'(varint_fifo_push & raw_data_fifo_push), 64'(0));
      chk("push_without_pop", 64'(in_fifo_pop), 64'(1));
      chk("push_into_full", 64'((varint_fifo_push & varint_fifo_full) |
                                (raw_data_fifo_push & raw_data_fifo_full)), 64'(0));
      chk("push_data", 64'(varint_fifo_push ? varint_fifo_data : raw_data_fifo_data),
          64'(in_fifo_q));
    end
    if (in_fifo_pop) chk("pop_when_empty", 64'(in_fifo_empty), 64'(0));
    if (varint_fifo_push)   got_v.push_back({varint_index, varint_fifo_data});
    if (raw_data_fifo_push) got_r.push_back({raw_data_index, raw_data_fifo_data});
    if (in_fifo_pop) begin
      pops++;
      if (src.size() != 0) void'(src.pop_front());
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b0; src.delete();
    v_full = 1'b0; r_full = 1'b0; hold_src = 1'b0; rand_mode = 1'b0;
    repeat (n) step();
    rst_drv = 1'b1;
    step();
    chk("clr_pulse", 64'({varint_fifo_clr, raw_data_fifo_clr}), 64'(2'b11));
    step();
    chk("clr_single", 64'({varint_fifo_clr, raw_data_fifo_clr}), 64'(0));
    got_v.delete(); got_r.delete(); pops = 0;
  endtask

  // Stream-level reference: walks the byte list field by field.
  task automatic model_parse();
    int p, idx, n, len;
    logic [7:0] b;
    p = 0; idx = 0; exp_err = 1'b0;
    exp_v.delete(); exp_r.delete();
    while (p < stream.size() && !exp_err) begin
      b = stream[p]; p++;
      if (b[7] || !(b[2:0] == 3'd0 || b[2:0] == 3'd2)) begin
        exp_err = 1'b1;
      end else if (b[2:0] == 3'd0) begin
        n = 0;
        while (p < stream.size()) begin
          b = stream[p]; p++; n++;
          exp_v.push_back({idx[9:0], b});
          if (!b[7]) begin idx = (idx + 1) % 1024; break; end
          if (n == 10) begin exp_err = 1'b1; break; end
        end
      end else if (p < stream.size()) begin
        len = int'(stream[p]); p++;
        if (len >= 128) exp_err = 1'b1;
        else begin
          for (int k = 0; k < len && p < stream.size(); k++) begin
            exp_r.push_back({idx[9:0], stream[p]}); p++;
          end
          if (len > 0) idx = (idx + 1) % 1024;
        end
      end
    end
    exp_pops = p;
  endtask

  task automatic gen_stream();
    int nf, nb, len, w;
    logic [3:0] fn;
    logic [7:0] b;
    stream.delete();
    nf = $urandom_range(1, 12);
    for (int f = 0; f < nf; f++) begin
      fn = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        nb = $urandom_range(1, 10);
        stream.push_back({1'b0, fn, 3'd0});
        for (int k = 0; k < nb; k++) begin
          b = 8'($urandom);
          b[7] = (k != nb - 1);
          stream.push_back(b);
        end
      end else begin
        len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
        stream.push_back({1'b0, fn, 3'd2});
        stream.push_back(8'(len));
        for (int k = 0; k < len; k++) stream.push_back(8'($urandom));
      end
    end
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: begin
          w = $urandom_range(3, 7);
          stream.push_back({1'b0, 4'($urandom), 3'(w)});
        end
        1: stream.push_back({1'b1, 7'($urandom)});
        2: begin
          stream.push_back(8'h08);
          for (int k = 0; k < 11; k++) stream.push_back({1'b1, 7'($urandom)});
        end
        default: begin
          stream.push_back(8'h0A);
          stream.push_back({1'b1, 7'($urandom)});
        end
      endcase
      for (int k = 0; k < 3; k++) stream.push_back(8'($urandom));
    end
  endtask

  typedef struct {
    int           n_in;
    logic [95:0]  in_s;
    int           n_v;
    logic [179:0] v_s;
    int           n_r;
    logic [71:0]  r_s;
    logic         err;
    int           pops;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [95:0]  ins;
    logic [179:0] vs;
    logic [71:0]  rs;
    logic [41:0]  all_out;

    vecs[0] = '{5, 96'({8'h08, 8'h96, 8'h01, 8'h08, 8'h00}),
                3, 180'({10'd0, 8'h96, 10'd0, 8'h01, 10'd1, 8'h00}), 0, 72'(0), 1'b0, 5};
    vecs[1] = '{7, 96'({8'h12, 8'h03, 8'h61, 8'h62, 8'h63, 8'h08, 8'h05}),
                1, 180'({10'd1, 8'h05}), 3, 72'({10'd0, 8'h61, 10'd0, 8'h62, 10'd0, 8'h63}),
                1'b0, 7};
    vecs[2] = '{4, 96'({8'h0A, 8'h00, 8'h08, 8'h01}), 1, 180'({10'd0, 8'h01}), 0, 72'(0),
                1'b0, 4};
    vecs[3] = '{3, 96'({8'h0D, 8'h08, 8'h01}), 0, 180'(0), 0, 72'(0), 1'b1, 1};
    vecs[4] = '{12, 96'({8'h08, {10{8'h80}}, 8'h01}), 10, 180'({10{10'd0, 8'h80}}),
                0, 72'(0), 1'b1, 11};
    vecs[5] = '{3, 96'({8'h88, 8'h08, 8'h01}), 0, 180'(0), 0, 72'(0), 1'b1, 1};
    vecs[6] = '{4, 96'({8'h0A, 8'h80, 8'h08, 8'h01}), 0, 180'(0), 0, 72'(0), 1'b1, 2};
    vecs[7] = '{12, 96'({8'h08, {8{8'h80}}, 8'h01, 8'h08, 8'h7F}),
                10, 180'({{8{10'd0, 8'h80}}, 10'd0, 8'h01, 10'd1, 8'h7F}), 0, 72'(0), 1'b0, 12};

    rst_drv = 1'b0; reset = 1'b0; in_fifo_empty = 1'b1; in_fifo_q = 8'h00;
    varint_fifo_full = 1'b0; raw_data_fifo_full = 1'b0;
    v_full = 1'b0; r_full = 1'b0; hold_src = 1'b0; rand_mode = 1'b0; pops = 0;

    // Reset state: outputs low even with a byte waiting, then one clr pulse.
    do_reset(2);
    src.push_back(8'h08); src.push_back(8'h01);
    rst_drv = 1'b0;
    step();
    all_out = {in_fifo_pop, varint_fifo_clr, varint_fifo_push, varint_fifo_data, varint_index,
               raw_data_fifo_clr, raw_data_fifo_push, raw_data_fifo_data, raw_data_index,
               parse_error};
    chk("reset_outputs_zero", 64'(all_out), 64'(0));
    do_reset(1);

    for (int i = 0; i < 8; i++) begin
      do_reset(1);
      ins = vecs[i].in_s; vs = vecs[i].v_s; rs = vecs[i].r_s;
      for (int k = 0; k < vecs[i].n_in; k++) src.push_back(ins[8*(vecs[i].n_in-1-k) +: 8]);
      run(vecs[i].n_in * 2 + 10);
      chk($sformatf("vec%0d_pops", i), 64'(pops), 64'(vecs[i].pops));
      chk($sformatf("vec%0d_err", i), 64'(parse_error), 64'(vecs[i].err));
      chk($sformatf("vec%0d_nv", i), 64'(got_v.size()), 64'(vecs[i].n_v));
      chk($sformatf("vec%0d_nr", i), 64'(got_r.size()), 64'(vecs[i].n_r));
      for (int k = 0; k < vecs[i].n_v && k < got_v.size(); k++)
        chk($sformatf("vec%0d_v%0d", i, k), 64'(got_v[k]), 64'(vs[18*(vecs[i].n_v-1-k) +: 18]));
      for (int k = 0; k < vecs[i].n_r && k < got_r.size(); k++)
        chk($sformatf("vec%0d_r%0d", i, k), 64'(got_r[k]), 64'(rs[18*(vecs[i].n_r-1-k) +: 18]));
    end

    // Raw destination held full for 5 cycles after the first payload byte.
    do_reset(1);
    src = '{8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
    for (int c = 0; c < 20 && got_r.size() < 1; c++) step();
    chk("stall_first_byte", 64'(got_r.size()), 64'(1));
    r_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_no_pop", 64'({in_fifo_pop, raw_data_fifo_push}), 64'(0));
    end
    chk("stall_pops_held", 64'(pops), 64'(3));
    r_full = 1'b0;
    run(10);
    chk("stall_nr", 64'(got_r.size()), 64'(3));
    if (got_r.size() == 3) begin
      chk("stall_r1", 64'(got_r[1]), 64'({10'd0, 8'h62}));
      chk("stall_r2", 64'(got_r[2]), 64'({10'd0, 8'h63}));
    end
    chk("stall_pops", 64'(pops), 64'(5));

    // Error is sticky, stops popping, and a one-cycle reset clears it.
    do_reset(1);
    src.push_back(8'h0D);
    run(3);
    chk("err_set", 64'(parse_error), 64'(1));
    src.push_back(8'h08); src.push_back(8'h01);
    run(4);
    chk("err_no_pop", 64'(pops), 64'(1));
    chk("err_no_push", 64'(got_v.size() + got_r.size()), 64'(0));
    chk("err_held", 64'(parse_error), 64'(1));
    rst_drv = 1'b0;
    step();
    chk("err_cleared_in_reset", 64'(parse_error), 64'(0));
    rst_drv = 1'b1;
    step();
    chk("err_clr_pulse", 64'({varint_fifo_clr, raw_data_fifo_clr}), 64'(2'b11));
    step();
    chk("err_cleared", 64'(parse_error), 64'(0));

    // Reset mid raw field: the partial field is abandoned.
    do_reset(1);
    src = '{8'h12, 8'h05, 8'h61, 8'h62, 8'h63};
    for (int c = 0; c < 20 && got_r.size() < 2; c++) step();
    rst_drv = 1'b0;
    step();
    chk("midreset_quiet", 64'({in_fifo_pop, raw_data_fifo_push, varint_fifo_push}), 64'(0));
    rst_drv = 1'b1;
    src.delete(); src.push_back(8'h08); src.push_back(8'h01);
    run(10);
    chk("midreset_nr", 64'(got_r.size()), 64'(2));
    chk("midreset_nv", 64'(got_v.size()), 64'(1));
    if (got_v.size() == 1) chk("midreset_v0", 64'(got_v[0]), 64'({10'd0, 8'h01}));

    // Field index wraps 1023 -> 0.
    do_reset(1);
    for (int k = 0; k < 1024; k++) begin src.push_back(8'h08); src.push_back(8'h00); end
    src.push_back(8'h08); src.push_back(8'h07);
    run(2070);
    chk("wrap_nv", 64'(got_v.size()), 64'(1025));
    if (got_v.size() == 1025) begin
      chk("wrap_1023", 64'(got_v[1023]), 64'({10'd1023, 8'h00}));
      chk("wrap_0", 64'(got_v[1024]), 64'({10'd0, 8'h07}));
    end
    chk("wrap_no_err", 64'(parse_error), 64'(0));

    // Randomized streams with random back-pressure and source gaps.
    for (int r = 0; r < 40; r++) begin
      do_reset(1);
      gen_stream();
      model_parse();
      foreach (stream[k]) src.push_back(stream[k]);
      rand_mode = 1'b1;
      run(stream.size() * 8 + 40);
      rand_mode = 1'b0; v_full = 1'b0; r_full = 1'b0; hold_src = 1'b0;
      step();
      chk("rnd_pops", 64'(pops), 64'(exp_pops));
      chk("rnd_err", 64'(parse_error), 64'(exp_err));
      chk("rnd_nv", 64'(got_v.size()), 64'(exp_v.size()));
      chk("rnd_nr", 64'(got_r.size()), 64'(exp_r.size()));
      for (int k = 0; k < got_v.size() && k < exp_v.size(); k++)
        chk("rnd_v", 64'(got_v[k]), 64'(exp_v[k]));
      for (int k = 0; k < got_r.size() && k < exp_r.size(); k++)
        chk("rnd_r", 64'(got_r[k]), 64'(exp_r[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/in_splitter.md
IN_SPLITTER -- requirements
Module: in_splitter

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset).
REQ-003 SHALL have port in_fifo_empty, input, 1: input FIFO holds no byte.
REQ-004 SHALL have port in_fifo_q, input, 8: head byte of the show-ahead input FIFO, valid when in_fifo_empty=0.
REQ-005 SHALL have port in_fifo_pop, output, 1: consume the head byte this cycle.
REQ-006 SHALL have port varint_fifo_full, input, 1: varint FIFO cannot accept a push.
REQ-007 SHALL have port varint_fifo_clr, output, 1: clear the varint FIFO.
REQ-008 SHALL have port varint_fifo_push, output, 1: write varint_fifo_data/varint_index this cycle.
REQ-009 SHALL have port varint_fifo_data, output, 8: varint payload byte.
REQ-010 SHALL have port varint_index, output, 10: field index of the pushed varint byte.
REQ-011 SHALL have port raw_data_fifo_full, input, 1: raw-data FIFO cannot accept a push.
REQ-012 SHALL have port raw_data_fifo_clr, output, 1: clear the raw-data FIFO.
REQ-013 SHALL have port raw_data_fifo_push, output, 1: write raw_data_fifo_data/raw_data_index this cycle.
REQ-014 SHALL have port raw_data_fifo_data, output, 8: length-delimited payload byte.
REQ-015 SHALL have port raw_data_index, output, 10: field index of the pushed raw byte.
REQ-016 SHALL have port parse_error, output, 1: sticky malformed-stream flag.

Function
REQ-017 SHALL parse a byte stream of single-byte keys: key[7] must be 0, key[2:0] = wire type, 0 = varint, 2 = length-delimited.
REQ-018 SHALL implement states INIT, KEY, LEN, V_DATA, R_DATA, ERROR, one-hot encoded, with unreachable encodings going to INIT.
REQ-019 INIT SHALL assert varint_fifo_clr and raw_data_fifo_clr for exactly one cycle, clear field_index and counters, then go to KEY.
REQ-020 KEY: when in_fifo_empty=0, SHALL pop one byte; wire type 0 -> V_DATA with varint byte count = 0; wire type 2 -> LEN; key[7]=1 or any other wire type -> ERROR.
REQ-021 LEN: when in_fifo_empty=0, SHALL pop one byte; q[7]=1 -> ERROR; q=0 -> KEY with field dropped and field_index unchanged; else remain <= q and go to R_DATA.
REQ-022 R_DATA: when in_fifo_empty=0 and raw_data_fifo_full=0, SHALL assert in_fifo_pop and raw_data_fifo_push in the same cycle, with raw_data_fifo_data = in_fifo_q and remain decremented; on the byte where remain=1, SHALL go to KEY and increment field_index.
REQ-023 V_DATA: when in_fifo_empty=0 and varint_fifo_full=0, SHALL pop and push in the same cycle, with varint_fifo_data = in_fifo_q and the count incremented; q[7]=0 -> KEY and increment field_index; q[7]=1 on the 10th byte -> ERROR.
REQ-024 SHALL never pop without the matching push in data states; a full destination or empty source stalls with pop=push=0 and all state held.
REQ-025 varint_index and raw_data_index SHALL both equal the field_index register (combinational); push and pop outputs are combinational from state and inputs.
REQ-026 field_index SHALL be 10 bits and wrap 1023 -> 0 without error.
REQ-027 Throughput SHALL be one payload byte per cycle when unstalled; each key/length byte costs one cycle; zero-cycle latency from pop to push.
REQ-028 ERROR SHALL set parse_error=1, hold it, and assert no pop or push until reset.
REQ-029 The two destinations SHALL never be pushed in the same cycle.

Reset
REQ-030 While reset=0, all outputs SHALL be 0, parse_error SHALL be cleared, and state SHALL be INIT.
REQ-031 On the first cycle with reset=1, both clr outputs SHALL be 1.
REQ-032 Reset asserted mid-field SHALL abandon the field with no further pop or push; the partial field is not resumed.

Verification
REQ-033 After reset, feed 08 96 01 -> varint pushes 0x96 then 0x01, both index 0; 3 pops; field_index = 1.
REQ-034 Feed 12 03 61 62 63 then 08 05 -> raw pushes 61,62,63 at index 0; varint push 05 at index 1.
REQ-035 During 12 03 61 62 63, hold raw_data_fifo_full=1 for 5 cycles after the first payload byte -> no pop or push while held; 62,63 then delivered in order, nothing lost or duplicated.
REQ-036 Feed 0A 00 08 01 -> no raw push; varint push 01 at index 0.
REQ-037 Feed key 0D -> parse_error=1 after the pop; no pushes; no further pops. Drive reset=0 for one cycle -> parse_error=0 and a clr pulse follows.
REQ-038 Feed 1024 copies of 08 00, then 08 07 -> 07 pushed at varint_index 0.
